// File: rtl/serial_sub_pkg.sv
// Shared FSM state type and default operand width for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell used by the serial datapath: d = a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock; Diff = (A - B) mod 2^WIDTH.
// Optional signed-overflow flag output ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             b_next;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (d_bit),
        .bout (b_next)
    );

    // Difference bits are shifted into the top of the minuend register as the
    // minuend drains out of the bottom; on the last bit a_sr[0]/b_sr[0] still
    // hold the operand sign bits needed for the overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= {d_bit, a_sr[WIDTH-1:1]};
                    b_sr   <= b_sr >> 1;
                    borrow <= b_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Diff  <= {d_bit, a_sr[WIDTH-1:1]};
                        Bout  <= b_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d_bit);
`endif
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, scoreboard on done, corner sequences.
// Define SERIAL_SUB_OVF_EN to also check the ovf output.
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } vec_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A     = '0;
    logic [WIDTH-1:0] B     = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    exp_t sb[$];
    vec_t tbl[12];
    int   passed = 0;
    int   total  = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.diff = a - b;
        e.bout = (a < b);
        e.ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ e.diff[WIDTH-1]);
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            check_output("busy_with_done", int'(busy), 0);
            if (sb.size() == 0) begin
                check_output("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check_output("diff", int'(Diff), int'(e.diff));
                check_output("bout", int'(Bout), int'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
                check_output("ovf", int'(ovf), int'(e.ovf));
`endif
            end
        end
    end

    task automatic wait_done(input string name);
        int cyc = 0;
        int busyc = 0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            cyc++;
            if (busy) busyc++;
            if (done) break;
        end
        check_output({name, "_latency"}, cyc, WIDTH + 1);
        check_output({name, "_busy_cycles"}, busyc, WIDTH);
    endtask

    task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input exp_t e, input string name);
        @(negedge clk);
        start = 1'b1;
        A     = a;
        B     = b;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        int   n;

        tbl[0]  = '{4'd9,  4'd3,  4'd6,  1'b0, 1'b1};
        tbl[1]  = '{4'd3,  4'd9,  4'd10, 1'b1, 1'b1};
        tbl[2]  = '{4'd0,  4'd1,  4'd15, 1'b1, 1'b0};
        tbl[3]  = '{4'd15, 4'd15, 4'd0,  1'b0, 1'b0};
        tbl[4]  = '{4'd8,  4'd1,  4'd7,  1'b0, 1'b1};
        tbl[5]  = '{4'd5,  4'd3,  4'd2,  1'b0, 1'b0};
        tbl[6]  = '{4'd7,  4'd8,  4'd15, 1'b1, 1'b1};
        tbl[7]  = '{4'd10, 4'd4,  4'd6,  1'b0, 1'b1};
        tbl[8]  = '{4'd4,  4'd10, 4'd10, 1'b1, 1'b1};
        tbl[9]  = '{4'd12, 4'd5,  4'd7,  1'b0, 1'b1};
        tbl[10] = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
        tbl[11] = '{4'd2,  4'd7,  4'd11, 1'b1, 1'b0};

        #12;
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_done", int'(done), 0);
        check_output("reset_diff", int'(Diff), 0);
        check_output("reset_bout", int'(Bout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            e = '{diff: tbl[i].diff, bout: tbl[i].bout, ovf: tbl[i].ovf};
            apply_stimulus(tbl[i].a, tbl[i].b, e, "table");
        end

        // start held through RUN with changing operands: one result, for 9-3
        @(negedge clk);
        start = 1'b1;
        A = 4'd9;
        B = 4'd3;
        sb.push_back('{diff: 4'd6, bout: 1'b0, ovf: 1'b1});
        @(posedge clk);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            A = WIDTH'($urandom);
            B = WIDTH'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        check_output("held_done_pulse", int'(done), 1);
        repeat (WIDTH + 3) @(negedge clk);
        check_output("held_single_busy", int'(busy), 0);
        check_output("held_sb_empty", sb.size(), 0);

        // back-to-back: restart on the done cycle
        @(negedge clk);
        start = 1'b1;
        A = 4'd12;
        B = 4'd5;
        sb.push_back('{diff: 4'd7, bout: 1'b0, ovf: 1'b1});
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check_output("b2b_first_done", int'(done), 1);
        start = 1'b1;
        A = 4'd2;
        B = 4'd7;
        sb.push_back('{diff: 4'd11, bout: 1'b1, ovf: 1'b0});
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        check_output("b2b_spacing", n, WIDTH + 1);

        // reset in the second RUN cycle abandons the operation
        @(negedge clk);
        start = 1'b1;
        A = 4'd9;
        B = 4'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_output("midreset_busy", int'(busy), 0);
        check_output("midreset_done", int'(done), 0);
        check_output("midreset_diff", int'(Diff), 0);
        check_output("midreset_bout", int'(Bout), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        A = 4'd3;
        B = 4'd9;
        sb.push_back('{diff: 4'd10, bout: 1'b1, ovf: 1'b1});
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("first_edge_after_reset");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                apply_stimulus(WIDTH'(a), WIDTH'(b), model(WIDTH'(a), WIDTH'(b)), "exhaustive");
            end
        end

        repeat (3) @(negedge clk);
        check_output("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
